// File: rtl/wti_time_master.sv
// rtl/wti_time_master.sv - WTI time-service master: 32.32 time-of-day, PPS and WR time streaming
// Optional feature macro: WTI_BUSY_COUNT_EN (saturating busy-suppressed cycle counter).
module wti_time_master #(
    parameter logic [31:0] INCR_RESET = 32'h0000_002B
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        incr_we,
    input  logic [31:0] incr_in,
    input  logic        set_we,
    input  logic [63:0] set_time,
    output logic [63:0] now,
    output logic        pps,
    output logic [2:0]  wti_MCmd,
    output logic [63:0] wti_MData,
    input  logic        wti_SThreadBusy,
    input  logic        wti_SReset_n,
    output logic [15:0] busy_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;

    logic [31:0] incr;
    logic [1:0]  state;
    logic [63:0] nowNext;

    assign nowNext = now + {32'd0, incr};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            incr <= INCR_RESET;
        end else if (incr_we) begin
            incr <= incr_in;
        end
    end

    // A set_we load replaces the increment for that cycle and never counts as a second tick.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            now <= 64'd0;
            pps <= 1'b0;
        end else if (set_we) begin
            now <= set_time;
            pps <= 1'b0;
        end else begin
            now <= nowNext;
            pps <= (nowNext[63:32] != now[63:32]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            wti_MCmd  <= CMD_IDLE;
            wti_MData <= 64'd0;
        end else if (!wti_SReset_n) begin
            state    <= ST_IDLE;
            wti_MCmd <= CMD_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_SYNC;
                    wti_MCmd <= CMD_IDLE;
                end
                ST_SYNC: begin
                    state    <= ST_RUN;
                    wti_MCmd <= CMD_IDLE;
                end
                ST_RUN: begin
                    if (wti_SThreadBusy) begin
                        wti_MCmd <= CMD_IDLE;
                    end else begin
                        wti_MCmd  <= CMD_WR;
                        wti_MData <= now;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wti_MCmd <= CMD_IDLE;
                end
            endcase
        end
    end

`ifdef WTI_BUSY_COUNT_EN
    // Cleared whenever the link falls back to IDLE so each slave session starts from zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_count <= 16'd0;
        end else if (!wti_SReset_n) begin
            busy_count <= 16'd0;
        end else if ((state == ST_RUN) && wti_SThreadBusy && (busy_count != 16'hFFFF)) begin
            busy_count <= busy_count + 16'd1;
        end
    end
`else
    assign busy_count = 16'd0;
`endif

endmodule

// File: tb/tb_wti_time_master.sv
// tb/tb_wti_time_master.sv - scoreboard bench for wti_time_master
module tb_wti_time_master;

    localparam logic [31:0] INCR_RESET = 32'h0000_002B;
`ifdef WTI_BUSY_COUNT_EN
    localparam logic [15:0] BUSY5 = 16'd5;
`else
    localparam logic [15:0] BUSY5 = 16'd0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        incr_we = 1'b0;
    logic [31:0] incr_in = 32'd0;
    logic        set_we = 1'b0;
    logic [63:0] set_time = 64'd0;
    logic [63:0] now;
    logic        pps;
    logic [2:0]  wti_MCmd;
    logic [63:0] wti_MData;
    logic        wti_SThreadBusy = 1'b0;
    logic        wti_SReset_n = 1'b0;
    logic [15:0] busy_count;

    wti_time_master #(.INCR_RESET(INCR_RESET)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .incr_we(incr_we), .incr_in(incr_in),
        .set_we(set_we), .set_time(set_time),
        .now(now), .pps(pps),
        .wti_MCmd(wti_MCmd), .wti_MData(wti_MData),
        .wti_SThreadBusy(wti_SThreadBusy), .wti_SReset_n(wti_SReset_n),
        .busy_count(busy_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] now;
        logic        pps;
        logic [2:0]  cmd;
        logic [63:0] data;
        logic [15:0] bc;
    } exp_t;

    exp_t expQ[$];
    int nChecks = 0;
    int nFails = 0;

    logic [63:0] mNow, mData;
    logic [31:0] mIncr;
    logic [15:0] mBusy;
    logic [2:0]  mCmd;
    logic        mPps;
    int          mState;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mNow = 64'd0; mData = 64'd0; mIncr = INCR_RESET; mBusy = 16'd0;
        mCmd = 3'd0; mPps = 1'b0; mState = 0;
    endtask

    // Predict the outputs after the coming edge, push them, then compare once the edge has passed.
    task automatic cyc();
        exp_t e;
        logic [32:0] fracSum;
        logic [63:0] preNow;
        preNow = mNow;
        if (!wti_SReset_n) begin
            mState = 0; mCmd = 3'd0; mBusy = 16'd0;
        end else if (mState == 0) begin
            mState = 1; mCmd = 3'd0;
        end else if (mState == 1) begin
            mState = 2; mCmd = 3'd0;
        end else if (wti_SThreadBusy) begin
            mCmd = 3'd0;
`ifdef WTI_BUSY_COUNT_EN
            if (mBusy != 16'hFFFF) mBusy = mBusy + 16'd1;
`endif
        end else begin
            mCmd = 3'd1; mData = preNow;
        end
        fracSum = {1'b0, preNow[31:0]} + {1'b0, mIncr};
        if (set_we) begin
            mNow = set_time; mPps = 1'b0;
        end else begin
            mNow = {preNow[63:32] + {31'd0, fracSum[32]}, fracSum[31:0]};
            mPps = fracSum[32];
        end
        if (incr_we) mIncr = incr_in;
        e.now = mNow; e.pps = mPps; e.cmd = mCmd; e.data = mData; e.bc = mBusy;
        expQ.push_back(e);
        @(posedge CLK);
        #1;
        e = expQ.pop_front();
        checkEq("sbNow", now, e.now);
        checkEq("sbPps", {63'd0, pps}, {63'd0, e.pps});
        checkEq("sbCmd", {61'd0, wti_MCmd}, {61'd0, e.cmd});
        checkEq("sbData", wti_MData, e.data);
        checkEq("sbBusyCount", {48'd0, busy_count}, {48'd0, e.bc});
    endtask

    initial begin
        int edges;
        logic [63:0] prev;
        modelReset();
        repeat (2) @(posedge CLK);
        #1;
        checkEq("rstNow", now, 64'd0);
        checkEq("rstPps", {63'd0, pps}, 64'd0);
        checkEq("rstCmd", {61'd0, wti_MCmd}, 64'd0);
        checkEq("rstData", wti_MData, 64'd0);
        checkEq("rstBusyCount", {48'd0, busy_count}, 64'd0);
        RST_N = 1'b1;

        incr_we = 1'b1; incr_in = 32'h10;
        cyc();
        checkEq("resetIncrStep", now, 64'h2B);
        incr_we = 1'b0;

        wti_SReset_n = 1'b1;
        edges = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            edges++;
            if (wti_MCmd == 3'b001) break;
        end
        checkEq("firstWrEdges", edges, 3);
        for (int i = 0; i < 3; i++) begin
            prev = wti_MData;
            cyc();
            checkEq("dataStep", wti_MData - prev, 64'h10);
        end

        prev = wti_MData;
        wti_SThreadBusy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checkEq("busyCmdIdle", {61'd0, wti_MCmd}, 64'd0);
        end
        checkEq("busyDataFrozen", wti_MData, prev);
        checkEq("busyCount5", {48'd0, busy_count}, {48'd0, BUSY5});
        wti_SThreadBusy = 1'b0;
        cyc();
        checkEq("busyReleaseWr", {61'd0, wti_MCmd}, 64'd1);

        set_we = 1'b1; set_time = 64'h0000_0005_FFFF_FFF0;
        cyc();
        checkEq("setNoPps", {63'd0, pps}, 64'd0);
        set_we = 1'b0;
        cyc();
        checkEq("setCarryNow", now, 64'h0000_0006_0000_0000);
        checkEq("setCarryPps", {63'd0, pps}, 64'd1);
        cyc();
        checkEq("ppsOneCycle", {63'd0, pps}, 64'd0);

        prev = now;
        wti_SReset_n = 1'b0;
        cyc();
        checkEq("sresetCmd", {61'd0, wti_MCmd}, 64'd0);
        checkEq("sresetNowRuns", now - prev, 64'h10);
        checkEq("sresetBusyClr", {48'd0, busy_count}, 64'd0);

        incr_we = 1'b1; incr_in = 32'h8000_0000;
        set_we = 1'b1; set_time = 64'hFFFF_FFFF_0000_0000;
        cyc();
        incr_we = 1'b0; set_we = 1'b0;
        cyc();
        checkEq("halfStepNow", now, 64'hFFFF_FFFF_8000_0000);
        cyc();
        checkEq("wrapNow", now, 64'd0);
        checkEq("wrapPps", {63'd0, pps}, 64'd1);
        for (int i = 0; i < 4; i++) cyc();

        #3;
        RST_N = 1'b0;
        #1;
        checkEq("asyncNow", now, 64'd0);
        checkEq("asyncPps", {63'd0, pps}, 64'd0);
        checkEq("asyncCmd", {61'd0, wti_MCmd}, 64'd0);
        checkEq("asyncData", wti_MData, 64'd0);
        checkEq("asyncBusyCount", {48'd0, busy_count}, 64'd0);
        modelReset();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cyc();
        checkEq("asyncIncrReset", now, {32'd0, INCR_RESET});
        wti_SReset_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
